// File: rtl/uart_rx_param_if.sv
// Signal bundle between a serial line driver and the uart_rx_param receiver.
// valid is a one-cycle pulse with no ready/backpressure: a consumer must take
// data/frame_err/parity_err in that cycle or read the held values later.
interface uart_rx_param_if #(
   parameter int DATA_BITS = 8
);
   logic                 tick;
   logic                 en;
   logic                 rx;
   logic [DATA_BITS-1:0] data;
   logic                 valid;
   logic                 busy;
   logic                 frame_err;
   logic                 parity_err;
   logic [2:0]           state_dbg;

   modport master (
      output tick, en, rx,
      input  data, valid, busy, frame_err, parity_err, state_dbg
   );

   modport slave (
      input  tick, en, rx,
      output data, valid, busy, frame_err, parity_err, state_dbg
   );
endinterface

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with configurable data bits, parity and stop bits.
// Define UART_RX_MAJORITY_EN to decide each bit by a 3-sample majority vote around mid-bit.
module uart_rx_param #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   uart_rx_param_if.slave bus
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS + 1);
`ifdef UART_RX_MAJORITY_EN
   localparam int DECIDE = OVERSAMPLE / 2 + 1;
`else
   localparam int DECIDE = OVERSAMPLE / 2;
`endif
   localparam logic [CW-1:0] DECIDE_IDX = CW'(DECIDE);
   localparam logic [CW-1:0] LAST_IDX   = CW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] LAST_DATA  = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] LAST_STOP  = BW'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   logic                 rx_s1, rx_s2, rx_sync;
   state_t               state, state_n;
   logic [CW-1:0]        cnt, cnt_n, cnt_inc;
   logic [BW-1:0]        bit_cnt, bit_n;
   logic [DATA_BITS-1:0] shreg, sh_n;
   logic                 fe_stg, fe_stg_n;
   logic                 pe_stg, pe_stg_n;
   logic                 armed, armed_n;
   logic                 commit;
   logic                 fe_final;
   logic                 sample_now, bit_end, bit_val, exp_par;
   logic [DATA_BITS-1:0] data_q;
   logic                 valid_q, fe_q, pe_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
      end else begin
         rx_s1 <= bus.rx;
         rx_s2 <= rx_s1;
      end
   end
   assign rx_sync = rx_s2;

   // cnt holds the index of the most recent tick inside the current bit; the
   // tick that detects the start edge is index 0, so cnt_inc is this tick's index.
   assign cnt_inc    = cnt + 1'b1;
   assign sample_now = bus.tick && (cnt_inc == DECIDE_IDX);
   assign bit_end    = bus.tick && (cnt_inc == LAST_IDX);
   assign exp_par    = (PARITY == 1) ? ~(^shreg) : (^shreg);

`ifdef UART_RX_MAJORITY_EN
   localparam logic [CW-1:0] PRE1_IDX = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] PRE2_IDX = CW'(OVERSAMPLE / 2);
   logic [1:0] hist;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist <= 2'b11;
      end else if (bus.tick) begin
         if (cnt_inc == PRE1_IDX) hist[1] <= rx_sync;
         if (cnt_inc == PRE2_IDX) hist[0] <= rx_sync;
      end
   end
   assign bit_val = (hist[1] & hist[0]) | (hist[1] & rx_sync) | (hist[0] & rx_sync);
`else
   assign bit_val = rx_sync;
`endif

   assign fe_final = fe_stg | ~bit_val;

   // armed blocks a new start until the line has been seen high on a tick,
   // which is what stops a held-low break from retriggering frames.
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      bit_n    = bit_cnt;
      sh_n     = shreg;
      fe_stg_n = fe_stg;
      pe_stg_n = pe_stg;
      armed_n  = armed | (bus.tick & rx_sync);
      commit   = 1'b0;
      if (!bus.en) begin
         state_n = ST_IDLE;
         armed_n = 1'b0;
      end else begin
         if (bus.tick && (state != ST_IDLE)) cnt_n = cnt_inc;
         case (state)
            ST_IDLE: begin
               if (bus.tick && !rx_sync && armed) begin
                  state_n  = ST_START;
                  cnt_n    = '0;
                  bit_n    = '0;
                  fe_stg_n = 1'b0;
                  pe_stg_n = 1'b0;
                  armed_n  = 1'b0;
               end
            end
            ST_START: begin
               if (sample_now && bit_val) begin
                  state_n = ST_IDLE;
               end else if (bit_end) begin
                  state_n = ST_DATA;
               end
            end
            ST_DATA: begin
               if (sample_now) sh_n = {bit_val, shreg[DATA_BITS-1:1]};
               if (bit_end) begin
                  if (bit_cnt == LAST_DATA) begin
                     bit_n   = '0;
                     state_n = (PARITY != 0) ? ST_PARITY : ST_STOP;
                  end else begin
                     bit_n = bit_cnt + 1'b1;
                  end
               end
            end
            ST_PARITY: begin
               if (sample_now) pe_stg_n = (bit_val != exp_par);
               if (bit_end) state_n = ST_STOP;
            end
            ST_STOP: begin
               if (sample_now) begin
                  if (bit_cnt == LAST_STOP) begin
                     commit  = 1'b1;
                     state_n = ST_IDLE;
                  end else begin
                     fe_stg_n = fe_final;
                  end
               end
               if (bit_end) bit_n = bit_cnt + 1'b1;
            end
            default: state_n = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         fe_stg  <= 1'b0;
         pe_stg  <= 1'b0;
         armed   <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         bit_cnt <= bit_n;
         shreg   <= sh_n;
         fe_stg  <= fe_stg_n;
         pe_stg  <= pe_stg_n;
         armed   <= armed_n;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         fe_q    <= 1'b0;
         pe_q    <= 1'b0;
      end else begin
         valid_q <= commit;
         if (commit) begin
            data_q <= shreg;
            fe_q   <= fe_final;
            pe_q   <= (PARITY != 0) && pe_stg;
         end
      end
   end

   assign bus.data       = data_q;
   assign bus.valid      = valid_q;
   assign bus.busy       = (state != ST_IDLE);
   assign bus.frame_err  = fe_q;
   assign bus.parity_err = pe_q;
   assign bus.state_dbg  = state;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8N1 receiver and a 7E1 receiver share one line.
module tb_uart_rx_param;

   logic clk = 1'b0;
   logic rst_n;
   logic tick_drv, en_drv, rx_drv;
   int   vectors = 0;
   int   miscompares = 0;
   int   vcnt8 = 0;
   int   vcnt7 = 0;
   int   busy_cyc = 0;

   always #5 clk = ~clk;

   uart_rx_param_if #(.DATA_BITS(8)) bus8 ();
   uart_rx_param_if #(.DATA_BITS(7)) bus7 ();

   assign bus8.tick = tick_drv;
   assign bus8.en   = en_drv;
   assign bus8.rx   = rx_drv;
   assign bus7.tick = tick_drv;
   assign bus7.en   = en_drv;
   assign bus7.rx   = rx_drv;

   uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .bus(bus8)
   );
   uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(16), .PARITY(2), .STOP_BITS(1)) u_dut7 (
      .clk(clk), .rst_n(rst_n), .bus(bus7)
   );

   always @(negedge clk) begin
      if (bus8.valid === 1'b1) vcnt8++;
      if (bus7.valid === 1'b1) vcnt7++;
      if (bus8.busy === 1'b1) busy_cyc++;
   end

   // one tick every 4 clocks; rx changes settle through the synchronizer before the tick
   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) begin
         repeat (3) @(negedge clk);
         tick_drv = 1'b1;
         @(negedge clk);
         tick_drv = 1'b0;
      end
   endtask

   task automatic send_ticks(input logic v, input int n);
      rx_drv = v;
      tick_n(n);
   endtask

   task automatic send_frame(input logic [8:0] word, input int nbits, input logic stop_v);
      send_ticks(1'b0, 16);
      for (int i = 0; i < nbits; i++) send_ticks(word[i], 16);
      send_ticks(stop_v, 16);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; tick_drv = 1'b0; en_drv = 1'b1; rx_drv = 1'b1;
      repeat (3) @(negedge clk);
      vectors++; if (bus8.data !== 8'h00) begin miscompares++; $display("FAIL rst_data got %h exp 00", bus8.data); end
      vectors++; if (bus8.valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b exp 0", bus8.valid); end
      vectors++; if (bus8.busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b exp 0", bus8.busy); end
      vectors++; if (bus8.frame_err !== 1'b0) begin miscompares++; $display("FAIL rst_fe got %b exp 0", bus8.frame_err); end
      vectors++; if (bus8.parity_err !== 1'b0) begin miscompares++; $display("FAIL rst_pe got %b exp 0", bus8.parity_err); end
      vectors++; if (bus8.state_dbg !== 3'd0) begin miscompares++; $display("FAIL rst_state got %0d exp 0", bus8.state_dbg); end
      vectors++; if (bus7.data !== 7'h00) begin miscompares++; $display("FAIL rst_data7 got %h exp 00", bus7.data); end
      rst_n = 1'b1;
      send_ticks(1'b1, 4);
   endtask

   task automatic test_8n1();
      int v0, b0, exp_b;
      exp_b = 608;
`ifdef UART_RX_MAJORITY_EN
      exp_b = 612;
`endif
      v0 = vcnt8; b0 = busy_cyc;
      send_frame(9'h0A5, 8, 1'b1);
      send_ticks(1'b1, 8);
      vectors++; if (vcnt8 - v0 !== 1) begin miscompares++; $display("FAIL a5_valid_count got %0d exp 1", vcnt8 - v0); end
      vectors++; if (bus8.data !== 8'hA5) begin miscompares++; $display("FAIL a5_data got %h exp a5", bus8.data); end
      vectors++; if (bus8.frame_err !== 1'b0) begin miscompares++; $display("FAIL a5_fe got %b exp 0", bus8.frame_err); end
      vectors++; if (bus8.parity_err !== 1'b0) begin miscompares++; $display("FAIL a5_pe got %b exp 0", bus8.parity_err); end
      vectors++; if (busy_cyc - b0 !== exp_b) begin miscompares++; $display("FAIL a5_busy_cycles got %0d exp %0d", busy_cyc - b0, exp_b); end
   endtask

   task automatic test_parity();
      int v0;
      v0 = vcnt7;
      send_frame({1'b0, 1'b1, 7'h41}, 8, 1'b1);
      send_ticks(1'b1, 8);
      vectors++; if (vcnt7 - v0 !== 1) begin miscompares++; $display("FAIL par1_valid_count got %0d exp 1", vcnt7 - v0); end
      vectors++; if (bus7.data !== 7'h41) begin miscompares++; $display("FAIL par1_data got %h exp 41", bus7.data); end
      vectors++; if (bus7.parity_err !== 1'b1) begin miscompares++; $display("FAIL par1_pe got %b exp 1", bus7.parity_err); end
      send_frame({1'b0, 1'b0, 7'h41}, 8, 1'b1);
      send_ticks(1'b1, 8);
      vectors++; if (bus7.data !== 7'h41) begin miscompares++; $display("FAIL par0_data got %h exp 41", bus7.data); end
      vectors++; if (bus7.parity_err !== 1'b0) begin miscompares++; $display("FAIL par0_pe got %b exp 0", bus7.parity_err); end
      vectors++; if (bus7.frame_err !== 1'b0) begin miscompares++; $display("FAIL par0_fe got %b exp 0", bus7.frame_err); end
   endtask

   task automatic test_glitch_reject();
      int v0, b0, exp_b;
      exp_b = 32;
`ifdef UART_RX_MAJORITY_EN
      exp_b = 36;
`endif
      v0 = vcnt8; b0 = busy_cyc;
      send_ticks(1'b0, 4);
      send_ticks(1'b1, 20);
      vectors++; if (vcnt8 - v0 !== 0) begin miscompares++; $display("FAIL glitch_valid_count got %0d exp 0", vcnt8 - v0); end
      vectors++; if (busy_cyc - b0 !== exp_b) begin miscompares++; $display("FAIL glitch_busy_cycles got %0d exp %0d", busy_cyc - b0, exp_b); end
      vectors++; if (bus8.busy !== 1'b0) begin miscompares++; $display("FAIL glitch_busy got %b exp 0", bus8.busy); end
      vectors++; if (bus8.frame_err !== 1'b0) begin miscompares++; $display("FAIL glitch_fe got %b exp 0", bus8.frame_err); end
      vectors++; if (bus8.data !== 8'h41) begin miscompares++; $display("FAIL glitch_data got %h exp 41", bus8.data); end
   endtask

   task automatic test_frame_err_break();
      int v0;
      v0 = vcnt8;
      send_frame(9'h03C, 8, 1'b0);
      vectors++; if (vcnt8 - v0 !== 1) begin miscompares++; $display("FAIL ferr_valid_count got %0d exp 1", vcnt8 - v0); end
      vectors++; if (bus8.data !== 8'h3C) begin miscompares++; $display("FAIL ferr_data got %h exp 3c", bus8.data); end
      vectors++; if (bus8.frame_err !== 1'b1) begin miscompares++; $display("FAIL ferr_fe got %b exp 1", bus8.frame_err); end
      send_ticks(1'b0, 320);
      vectors++; if (vcnt8 - v0 !== 2) begin miscompares++; $display("FAIL break_valid_count got %0d exp 2", vcnt8 - v0); end
      vectors++; if (bus8.data !== 8'h00) begin miscompares++; $display("FAIL break_data got %h exp 00", bus8.data); end
      vectors++; if (bus8.frame_err !== 1'b1) begin miscompares++; $display("FAIL break_fe got %b exp 1", bus8.frame_err); end
      send_ticks(1'b1, 16);
   endtask

   task automatic test_enable_drop();
      int v0;
      v0 = vcnt8;
      send_ticks(1'b0, 16);
      send_ticks(1'b1, 48);
      send_ticks(1'b1, 4);
      en_drv = 1'b0;
      repeat (2) @(negedge clk);
      vectors++; if (bus8.state_dbg !== 3'd0) begin miscompares++; $display("FAIL en_state got %0d exp 0", bus8.state_dbg); end
      vectors++; if (bus8.busy !== 1'b0) begin miscompares++; $display("FAIL en_busy got %b exp 0", bus8.busy); end
      vectors++; if (bus8.data !== 8'h00) begin miscompares++; $display("FAIL en_data_held got %h exp 00", bus8.data); end
      vectors++; if (bus8.frame_err !== 1'b1) begin miscompares++; $display("FAIL en_fe_held got %b exp 1", bus8.frame_err); end
      en_drv = 1'b1;
      send_ticks(1'b1, 12 + 64 + 16 + 8);
      send_frame(9'h012, 8, 1'b1);
      send_ticks(1'b1, 8);
      vectors++; if (vcnt8 - v0 !== 1) begin miscompares++; $display("FAIL en_valid_count got %0d exp 1", vcnt8 - v0); end
      vectors++; if (bus8.data !== 8'h12) begin miscompares++; $display("FAIL en_data got %h exp 12", bus8.data); end
      vectors++; if (bus8.frame_err !== 1'b0) begin miscompares++; $display("FAIL en_fe got %b exp 0", bus8.frame_err); end
   endtask

   task automatic test_majority_glitch();
      int v0;
      logic [7:0] exp_d;
      exp_d = 8'h00;
`ifdef UART_RX_MAJORITY_EN
      exp_d = 8'h01;
`endif
      v0 = vcnt8;
      send_ticks(1'b0, 16);
      send_ticks(1'b1, 8);
      send_ticks(1'b0, 1);
      send_ticks(1'b1, 7);
      send_ticks(1'b0, 7 * 16);
      send_ticks(1'b1, 16 + 8);
      vectors++; if (vcnt8 - v0 !== 1) begin miscompares++; $display("FAIL maj_valid_count got %0d exp 1", vcnt8 - v0); end
      vectors++; if (bus8.data !== exp_d) begin miscompares++; $display("FAIL maj_data got %h exp %h", bus8.data, exp_d); end
   endtask

   task automatic test_reset_mid_frame();
      int v0;
      v0 = vcnt8;
      send_ticks(1'b0, 32);
      send_ticks(1'b0, 5);
      rst_n = 1'b0;
      #1;
      vectors++; if (bus8.busy !== 1'b0) begin miscompares++; $display("FAIL rmid_busy got %b exp 0", bus8.busy); end
      vectors++; if (bus8.state_dbg !== 3'd0) begin miscompares++; $display("FAIL rmid_state got %0d exp 0", bus8.state_dbg); end
      vectors++; if (bus8.data !== 8'h00) begin miscompares++; $display("FAIL rmid_data got %h exp 00", bus8.data); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      send_ticks(1'b0, 11);
      send_ticks(1'b1, 8 * 16);
      vectors++; if (vcnt8 - v0 !== 0) begin miscompares++; $display("FAIL rmid_valid_count got %0d exp 0", vcnt8 - v0); end
      vectors++; if (bus8.busy !== 1'b0) begin miscompares++; $display("FAIL rmid_busy_after got %b exp 0", bus8.busy); end
      vectors++; if (bus8.frame_err !== 1'b0) begin miscompares++; $display("FAIL rmid_fe got %b exp 0", bus8.frame_err); end
   endtask

   initial begin
      test_reset();
      test_8n1();
      test_parity();
      test_glitch_reject();
      test_frame_err_break();
      test_enable_drop();
      test_majority_glitch();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
